// File: rtl/picomem_uart_pkg.sv
// Shared definitions for the buffered PicoMem UART bridge: CPU register map,
// STATUS layout, UART-side request payload and master FSM encoding.
package picomem_uart_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_DIV    = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } cpu_reg_e;

  localparam logic [BUS_W-1:0] UART_DATA_ADDR = 32'h0000_0000;
  localparam logic [BUS_W-1:0] UART_DIV_ADDR  = 32'h0000_0004;

  localparam int unsigned ST_TX_EMPTY     = 0;
  localparam int unsigned ST_RX_NONEMPTY  = 1;
  localparam int unsigned ST_TX_FULL      = 2;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_WR = 2'd1,
    TX_WR  = 2'd2,
    RX_RD  = 2'd3
  } mstate_e;

  typedef struct packed {
    logic [BUS_W-1:0]  addr;
    logic [BUS_W-1:0]  wdata;
    logic [STRB_W-1:0] wstrb;
  } m_req_t;

  function automatic logic [BUS_W-1:0] status_word(
    input logic       tx_empty,
    input logic       rx_nonempty,
    input logic       tx_full,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    logic [BUS_W-1:0] w;
    w                          = '0;
    w[ST_TX_EMPTY]             = tx_empty;
    w[ST_RX_NONEMPTY]          = rx_nonempty;
    w[ST_TX_FULL]              = tx_full;
    w[ST_TX_COUNT_LSB +: 8]    = tx_cnt;
    w[ST_RX_COUNT_LSB +: 8]    = rx_cnt;
    return w;
  endfunction

endpackage

// File: rtl/picomem_byte_fifo.sv
// Byte FIFO with registered head output; simultaneous push and pop both take
// effect, a push into a full FIFO without a pop is dropped.
module picomem_byte_fifo
  import picomem_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     ext_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = dout_q;

  // Head is recomputed from the post-update pointer and storage.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    dout_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/picomem_uart_fifo_bridge.sv
// Buffered PicoMem front-end for the UART slave: CPU decode into TX/RX byte
// FIFOs, a divider mailbox, an RX poll timer and the UART-side master FSM.
module picomem_uart_fifo_bridge
  import picomem_uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned POLL_CYCLES = 64
) (
  input  logic              clk,
  input  logic              ext_reset,
  input  logic              s_valid,
  input  logic [BUS_W-1:0]  s_addr,
  input  logic [BUS_W-1:0]  s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  output logic              s_ready,
  output logic [BUS_W-1:0]  s_rdata,
  output logic              m_valid,
  output logic [BUS_W-1:0]  m_addr,
  output logic [BUS_W-1:0]  m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_ready,
  input  logic [BUS_W-1:0]  m_rdata
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(POLL_CYCLES) + 1;

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [BYTE_W-1:0] tx_dout, rx_dout;
  logic [CW-1:0]     tx_count, rx_count;

  logic              s_ready_q, s_ready_d;
  logic [BUS_W-1:0]  s_rdata_q, s_rdata_d;
  logic              div_pending_q, div_pending_d;
  logic [BUS_W-1:0]  div_wdata_q, div_wdata_d;
  logic [STRB_W-1:0] div_wstrb_q, div_wstrb_d;
  logic              div_set, div_clr;
  logic              m_valid_q, m_valid_d;
  m_req_t            m_req_q, m_req_d;
  mstate_e           state_q, state_d;
  logic [TW-1:0]     poll_q, poll_d;
  logic              rx_pri_q, rx_pri_d;
  cpu_reg_e          reg_sel;
  logic              is_wr, stall, accept, tx_job, rx_job;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{s_addr[BUS_W-1:4], s_addr[1:0]};

  picomem_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .ext_reset(ext_reset), .push(tx_push), .pop(tx_pop),
    .din(s_wdata[BYTE_W-1:0]), .dout(tx_dout), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  picomem_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .ext_reset(ext_reset), .push(rx_push), .pop(rx_pop),
    .din(m_rdata[BYTE_W-1:0]), .dout(rx_dout), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  // CPU-side decode: one request per s_ready pulse, writes stall on back-pressure.
  always_comb begin
    reg_sel   = cpu_reg_e'(s_addr[3:2]);
    is_wr     = |s_wstrb;
    s_ready_d = 1'b0;
    s_rdata_d = s_rdata_q;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    div_set   = 1'b0;
    stall     = 1'b0;
    case (reg_sel)
      REG_DATA: stall = is_wr && s_wstrb[0] && tx_full;
      REG_DIV:  stall = is_wr && div_pending_q;
      default:  stall = 1'b0;
    endcase
    accept = s_valid && !s_ready_q && !stall;
    if (accept) begin
      s_ready_d = 1'b1;
      s_rdata_d = '0;
      case (reg_sel)
        REG_DATA: begin
          if (is_wr) begin
            tx_push = s_wstrb[0];
          end else if (rx_empty) begin
            s_rdata_d = '1;
          end else begin
            s_rdata_d = BUS_W'(rx_dout);
            rx_pop    = 1'b1;
          end
        end
        REG_DIV: div_set = is_wr;
        REG_STATUS: begin
          if (!is_wr) begin
            s_rdata_d = status_word(tx_empty, !rx_empty, tx_full,
                                    8'(tx_count), 8'(rx_count));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    div_pending_d = (div_pending_q && !div_clr) || div_set;
    div_wdata_d   = div_set ? s_wdata : div_wdata_q;
    div_wstrb_d   = div_set ? s_wstrb : div_wstrb_q;
  end

  // Master FSM: IDLE picks DIV first, then alternates between TX and RX jobs.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_req_d   = m_req_q;
    rx_pri_d  = rx_pri_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    div_clr   = 1'b0;
    poll_d    = (poll_q != '0) ? poll_q - TW'(1) : poll_q;
    tx_job    = !tx_empty;
    rx_job    = !rx_full && (poll_q == '0);
    case (state_q)
      IDLE: begin
        if (div_pending_q) begin
          state_d       = DIV_WR;
          m_valid_d     = 1'b1;
          m_req_d.addr  = UART_DIV_ADDR;
          m_req_d.wdata = div_wdata_q;
          m_req_d.wstrb = div_wstrb_q;
        end else if (tx_job && (!rx_job || !rx_pri_q)) begin
          state_d       = TX_WR;
          m_valid_d     = 1'b1;
          m_req_d.addr  = UART_DATA_ADDR;
          m_req_d.wdata = BUS_W'(tx_dout);
          m_req_d.wstrb = 4'b0001;
          rx_pri_d      = 1'b1;
        end else if (rx_job) begin
          state_d       = RX_RD;
          m_valid_d     = 1'b1;
          m_req_d.addr  = UART_DATA_ADDR;
          m_req_d.wdata = '0;
          m_req_d.wstrb = '0;
          rx_pri_d      = 1'b0;
        end
      end
      DIV_WR: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          div_clr   = 1'b1;
        end
      end
      TX_WR: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          tx_pop    = 1'b1;
        end
      end
      RX_RD: begin
        if (m_ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          rx_push   = (m_rdata[BUS_W-1:BYTE_W] == '0);
          poll_d    = TW'(POLL_CYCLES - 1);
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      s_ready_q     <= 1'b0;
      s_rdata_q     <= '0;
      div_pending_q <= 1'b0;
      div_wdata_q   <= '0;
      div_wstrb_q   <= '0;
      state_q       <= IDLE;
      m_valid_q     <= 1'b0;
      m_req_q       <= '0;
      poll_q        <= '0;
      rx_pri_q      <= 1'b0;
    end else begin
      s_ready_q     <= s_ready_d;
      s_rdata_q     <= s_rdata_d;
      div_pending_q <= div_pending_d;
      div_wdata_q   <= div_wdata_d;
      div_wstrb_q   <= div_wstrb_d;
      state_q       <= state_d;
      m_valid_q     <= m_valid_d;
      m_req_q       <= m_req_d;
      poll_q        <= poll_d;
      rx_pri_q      <= rx_pri_d;
    end
  end

  assign s_ready = s_ready_q;
  assign s_rdata = s_rdata_q;
  assign m_valid = m_valid_q;
  assign m_addr  = m_req_q.addr;
  assign m_wdata = m_req_q.wdata;
  assign m_wstrb = m_req_q.wstrb;

endmodule

// File: tb/tb_picomem_uart_fifo_bridge.sv
// Directed bench for the PicoMem UART FIFO bridge with a small behavioural
// UART slave whose data-write and read readiness the stimulus controls.
module tb_picomem_uart_fifo_bridge;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned POLL  = 20;

  logic        clk = 1'b0;
  logic        ext_reset;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic tx_ready_en, rd_ready_en;
  int   rx_offers = 0;
  int   rx_served = 0;
  logic rx_has;
  logic [7:0] rx_byte = 8'h55;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_strb[$];
  int          poll_t[$];

  always #5 clk = ~clk;

  picomem_uart_fifo_bridge #(.DEPTH(DEPTH), .POLL_CYCLES(POLL)) dut (
    .clk(clk), .ext_reset(ext_reset),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  // Behavioural UART slave: combinational ready, one optional held RX byte.
  assign rx_has = (rx_offers > rx_served);
  always_comb begin
    m_ready = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    if (m_valid) begin
      if (m_wstrb == 4'h0) begin
        m_ready = rd_ready_en;
        m_rdata = rx_has ? {24'h0, rx_byte} : 32'hFFFF_FFFF;
      end else if (m_addr == 32'h0) begin
        m_ready = tx_ready_en;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ext_reset && m_valid && m_ready) begin
      if (m_wstrb != 4'h0) begin
        log_addr.push_back(m_addr);
        log_data.push_back(m_wdata);
        log_strb.push_back(m_wstrb);
      end else begin
        poll_t.push_back(cyc);
        if (rx_has) rx_served <= rx_served + 1;
      end
    end
  end

  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata,
                            output int lat);
    s_valid = 1'b1; s_addr = addr; s_wdata = wdata; s_wstrb = wstrb; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!s_ready && lat < 200);
    if (!s_ready) begin
      checks++; fails++;
      $display("FAIL cpu_timeout: addr %h no s_ready after %0d cycles", addr, lat);
    end
    rdata = s_rdata;
    s_valid = 1'b0; s_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    ext_reset = 1'b0; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    tx_ready_en = 1'b1; rd_ready_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b rdata=%h mv=%b ma=%h mw=%h ms=%h required all 0",
               s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb);
    end
    ext_reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin
      fails++; $display("FAIL reset_status: got %h required %h", rd, 32'h1);
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] rd; int lat; int base;
    tx_ready_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_access(32'h0, 32'h41 + 32'(i), 4'h1, rd, lat);
      checks++;
      if (lat !== 1) begin
        fails++; $display("FAIL tx_write_latency[%0d]: got %0d required 1", i, lat);
      end
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0300) begin
      fails++; $display("FAIL tx_status_count3: got %h required %h", rd, 32'h300);
    end
    base = log_addr.size();
    tx_ready_en = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (log_addr.size() - base !== 3) begin
      fails++; $display("FAIL tx_write_count: got %0d required 3", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({log_addr[base+i], log_data[base+i], log_strb[base+i]} !==
            {32'h0, 32'h41 + 32'(i), 4'h1}) begin
          fails++;
          $display("FAIL tx_write_order[%0d]: got addr=%h data=%h strb=%h required addr=0 data=%h strb=1",
                   i, log_addr[base+i], log_data[base+i], log_strb[base+i], 32'h41 + 32'(i));
        end
      end
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin
      fails++; $display("FAIL tx_status_drained: got %h required %h", rd, 32'h1);
    end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd; int lat; int base; int bad_lat; int early; int bad_order;
    tx_ready_en = 1'b0;
    base = log_addr.size();
    bad_lat = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_access(32'h0, 32'h10 + 32'(i), 4'h1, rd, lat);
      if (lat != 1) bad_lat++;
    end
    checks++;
    if (bad_lat !== 0) begin
      fails++; $display("FAIL fill_latency: got %0d slow writes required 0", bad_lat);
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_1004) begin
      fails++; $display("FAIL full_status: got %h required %h", rd, 32'h1004);
    end
    s_valid = 1'b1; s_addr = 32'h0; s_wdata = 32'h20; s_wstrb = 4'h1;
    early = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (s_ready) early++;
    end
    checks++;
    if (early !== 0) begin
      fails++; $display("FAIL full_stall: got %0d early acks required 0", early);
    end
    tx_ready_en = 1'b1;
    @(posedge clk); #1;
    tx_ready_en = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!s_ready && lat < 20);
    s_valid = 1'b0; s_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (lat !== 1) begin
      fails++; $display("FAIL stall_release_latency: got %0d required 1", lat);
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_1004) begin
      fails++; $display("FAIL refull_status: got %h required %h", rd, 32'h1004);
    end
    tx_ready_en = 1'b1;
    repeat (120) @(posedge clk); #1;
    checks++;
    if (log_addr.size() - base !== DEPTH + 1) begin
      fails++; $display("FAIL fill_drain_count: got %0d required %0d", log_addr.size() - base, DEPTH + 1);
    end else begin
      bad_order = 0;
      for (int i = 0; i <= DEPTH; i++)
        if (log_data[base+i] !== 32'h10 + 32'(i)) bad_order++;
      checks++;
      if (bad_order !== 0) begin
        fails++; $display("FAIL fill_drain_order: got %0d wrong bytes required 0", bad_order);
      end
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin
      fails++; $display("FAIL full_drained_status: got %h required %h", rd, 32'h1);
    end
  endtask

  task automatic test_rx_poll();
    logic [31:0] rd; int lat; int pbase; int min_gap;
    pbase = poll_t.size();
    rx_offers = rx_offers + 1;
    repeat (3 * POLL + 10) @(posedge clk); #1;
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0001_0003) begin
      fails++; $display("FAIL rx_status: got %h required %h", rd, 32'h0001_0003);
    end
    checks++;
    if (poll_t.size() - pbase < 2) begin
      fails++; $display("FAIL rx_poll_count: got %0d required >=2", poll_t.size() - pbase);
    end else begin
      min_gap = 1000000;
      for (int i = pbase + 1; i < poll_t.size(); i++)
        if (poll_t[i] - poll_t[i-1] < min_gap) min_gap = poll_t[i] - poll_t[i-1];
      checks++;
      if (min_gap < POLL) begin
        fails++; $display("FAIL rx_poll_spacing: got %0d required >=%0d", min_gap, POLL);
      end
    end
    cpu_access(32'h0, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0055) begin
      fails++; $display("FAIL rx_read_byte: got %h required %h", rd, 32'h55);
    end
    cpu_access(32'h0, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL rx_read_empty: got %h required %h", rd, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_div_priority();
    logic [31:0] rd; int lat; int base; int waited;
    rd_ready_en = 1'b0;
    waited = 0;
    while (!(m_valid && m_wstrb == 4'h0) && waited < 4 * POLL) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (!(m_valid && m_wstrb == 4'h0)) begin
      fails++; $display("FAIL div_wait_poll: got m_valid=%b after %0d cycles required stuck poll", m_valid, waited);
    end
    base = log_addr.size();
    cpu_access(32'h0, 32'h61, 4'h1, rd, lat);
    cpu_access(32'h4, 32'h0000_00EA, 4'hF, rd, lat);
    checks++;
    if (lat !== 1) begin
      fails++; $display("FAIL div_write_latency: got %0d required 1", lat);
    end
    rd_ready_en = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++;
    if (log_addr.size() - base !== 2) begin
      fails++; $display("FAIL div_tx_count: got %0d required 2", log_addr.size() - base);
    end else begin
      checks++;
      if ({log_addr[base], log_data[base], log_strb[base]} !== {32'h4, 32'hEA, 4'hF}) begin
        fails++;
        $display("FAIL div_first: got addr=%h data=%h strb=%h required addr=4 data=ea strb=f",
                 log_addr[base], log_data[base], log_strb[base]);
      end
      checks++;
      if ({log_addr[base+1], log_data[base+1], log_strb[base+1]} !== {32'h0, 32'h61, 4'h1}) begin
        fails++;
        $display("FAIL div_then_tx: got addr=%h data=%h strb=%h required addr=0 data=61 strb=1",
                 log_addr[base+1], log_data[base+1], log_strb[base+1]);
      end
    end
    cpu_access(32'h4, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL div_read_zero: got %h required 0", rd);
    end
    cpu_access(32'hC, 32'h1234_5678, 4'hF, rd, lat);
    cpu_access(32'hC, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL rsvd_read_zero: got %h required 0", rd);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] rd; int lat; int base;
    tx_ready_en = 1'b0;
    for (int i = 0; i < 5; i++) cpu_access(32'h0, 32'h71 + 32'(i), 4'h1, rd, lat);
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({m_valid, m_addr, m_wdata, m_wstrb} !== {1'b1, 32'h0, 32'h71, 4'h1}) begin
      fails++;
      $display("FAIL rst_tx_inflight: got mv=%b addr=%h data=%h strb=%h required mv=1 addr=0 data=71 strb=1",
               m_valid, m_addr, m_wdata, m_wstrb);
    end
    base = log_addr.size();
    ext_reset = 1'b0;
    #1;
    checks++;
    if ({m_valid, s_ready} !== 2'b00) begin
      fails++; $display("FAIL rst_async_drop: got m_valid=%b s_ready=%b required 0 0", m_valid, s_ready);
    end
    tx_ready_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    ext_reset = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++;
    if (log_addr.size() - base !== 0) begin
      fails++; $display("FAIL rst_stale_writes: got %0d writes required 0", log_addr.size() - base);
    end
    cpu_access(32'h8, 32'h0, 4'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin
      fails++; $display("FAIL rst_status: got %h required %h", rd, 32'h1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_poll();
    test_div_priority();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/picomem_uart_fifo_bridge.md
# picomem_uart_fifo_bridge

Buffered UART front-end between the PicoMem address mux (slave side) and the existing PicoMem UART slave (master side). CPU writes land in a TX byte FIFO and are drained into the UART data register as the transmitter frees up. A poll engine reads the UART data register and stores received bytes in an RX FIFO. The CPU therefore never stalls on a busy transmitter unless the TX FIFO is full, and received bytes survive between CPU polls.

## Interface
- DEPTH, 16: entries per FIFO; power of 2, 2..128.
- POLL_CYCLES, 64: minimum clk cycles between RX polls of the UART; ≥1.
- clk  in  1  system clock (same domain as the UART slave's cpu_clk).
- ext_reset  in  1  reset, asynchronous, active-low; clears every flop.
- s_valid / s_addr / s_wdata / s_wstrb  in  1/32/32/4  CPU-side PicoMem request.
- s_ready  out  1  CPU-side completion pulse; reset 0.
- s_rdata  out  32  CPU-side read data; reset 0.
- m_valid  out  1  UART-side request; reset 0.
- m_addr  out  32  UART-side address: 0x0 data, 0x4 divider; reset 0.
- m_wdata / m_wstrb  out  32/4  UART-side write data/strobes; reset 0.
- m_ready  in  1  UART-side completion (combinational in the UART).
- m_rdata  in  32  UART-side read data: {24'b0, byte} if a byte is held, else 0xFFFFFFFF.

## Operation
- CPU register map, decoded on s_addr[3:2]:
  - 0x0 DATA: write with wstrb[0] pushes wdata[7:0] to TX FIFO. Read pops the RX FIFO and returns {24'b0, byte}, or 0xFFFFFFFF when empty.
  - 0x4 DIV: write latches wdata/wstrb into div_pending. The value is forwarded to UART 0x4. Read returns 0.
  - 0x8 STATUS (read-only): [0] tx_empty, [1] rx_nonempty, [2] tx_full, [15:8] tx_count, [23:16] rx_count.
  - 0xC: read returns 0; write is acknowledged and ignored.
- CPU acceptance: a request is accepted when s_valid && !s_ready. Stall conditions:
  - DATA write stalls while TX is full.
  - DIV write stalls while div_pending is set.
  - Every other access is never stalled.
- Master FSM states:
  - IDLE: selects the next job, priority DIV > round-robin(TX, RX). TX needs tx_count>0. RX needs rx_count<DEPTH and poll timer == 0.
  - DIV_WR: m_addr=4, strobes = latched wstrb.
  - TX_WR: m_addr=0, m_wstrb=4'b0001, m_wdata = {24'b0, TX head}.
  - RX_RD: m_addr=0, m_wstrb=0.
- In every non-IDLE state, m_valid is held with constant address/data until m_ready. Then:
  - DIV_WR clears div_pending.
  - TX_WR pops TX.
  - RX_RD pushes m_rdata[7:0] only if m_rdata[31:8]==0, and reloads the poll timer to POLL_CYCLES-1.
  - FSM returns to IDLE.
- RX_RD is never issued while RX is full. Bytes stay in the UART, so the FIFO cannot overflow.
- Round robin: after a TX_WR, RX has priority at the next IDLE decision, and vice versa.

## Timing
- s_ready is a registered one-cycle pulse, the cycle after acceptance. s_rdata is valid in the same cycle and holds until the next acceptance.
- Minimum CPU access latency is 1 cycle. A stalled write completes 1 cycle after the blocking condition clears.
- Master side: m_valid rises 1 cycle after the IDLE decision and falls the cycle after m_ready. There is at least one IDLE cycle between transactions.
- The UART holds m_ready low for a data write while its transmitter is busy. TX_WR simply waits.
- Simultaneous push and pop on one FIFO: both execute, and the count is unchanged.
- Status and empty/full checks use the pre-update count. A CPU read of an empty RX in the same cycle as an FSM push returns 0xFFFFFFFF; the byte remains.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits, zero-extended into the STATUS fields.
- ext_reset low mid-transaction immediately:
  - drops m_valid and s_ready;
  - empties both FIFOs;
  - clears div_pending;
  - zeroes the poll timer.

## Structure
- Package picomem_uart_pkg: register offsets, STATUS bit positions, and the FSM state encoding (IDLE, DIV_WR, TX_WR, RX_RD).
- Sub-module picomem_byte_fifo (DEPTH parameter; push, pop, din, dout, count, full, empty), instantiated twice for TX and RX.
- The top level holds the CPU decode, the poll timer and the master FSM.

## Test plan
- Reset state: all outputs are 0. STATUS reads 0x00000001.
- Write 0x41, 0x42, 0x43 to DATA with m_ready held low. Expected:
  - each CPU access acks in 1 cycle;
  - STATUS reads tx_count=3;
  - after m_ready is released, UART sees three writes in order 0x41, 0x42, 0x43.
- Fill TX to DEPTH with m_ready low. Expected:
  - the 17th DATA write stalls;
  - a single m_ready pulse completes it;
  - tx_full toggles correctly.
- Model the UART returning 0x55 and then 0xFFFFFFFF. Expected:
  - after one poll, RX holds 0x55 and the next poll pushes nothing;
  - CPU DATA read returns 0x00000055, then 0xFFFFFFFF;
  - poll spacing is ≥ POLL_CYCLES.
- DIV write 0x000000EA with TX non-empty. Expected: the DIV transaction is issued before any TX_WR, with m_addr=4 and m_wstrb=4'hF.
- Pull ext_reset low during TX_WR with 5 bytes queued. Expected:
  - m_valid drops immediately;
  - after release, STATUS=0x00000001 and no stale writes reach the UART.
